// File: rtl/updown_counter_hex_display.sv
// Up/down counter with synchronous load, programmable modulus and a
// wrap/saturate mode. The count is shown on a time-multiplexed
// multi-digit hex 7-segment display.
module updown_counter_hex_display #(
  parameter int   NBITS     = 8,
  parameter int   MAX_COUNT = 2**NBITS - 1,
  parameter bit   WRAP      = 1'b1,
  parameter int   SCAN_DIV  = 4,
  localparam int  NDIGITS   = (NBITS + 3) / 4
) (
  input  logic               clk_2,
  input  logic               reset,
  input  logic               load,
  input  logic [NBITS-1:0]   data_in,
  input  logic               counter_on,
  input  logic               count_up,
  output logic [NBITS-1:0]   count,
  output logic               tc,
  output logic [7:0]         seg,
  output logic [NDIGITS-1:0] digit_sel
);

  localparam logic [NBITS-1:0] MAXV = NBITS'(MAX_COUNT);
  localparam int PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int PADW = 4 * NDIGITS;

  logic [NBITS-1:0]   r_count;
  logic               r_tc;
  logic [PW-1:0]      r_presc;
  logic [IW-1:0]      r_idx;
  logic [7:0]         r_seg;
  logic [NDIGITS-1:0] r_dsel;

  logic [NBITS-1:0]   w_load_val;
  logic [PADW-1:0]    w_pad;
  logic [3:0]         w_nib;

  // Hex digit to active-high segment pattern (a = bit0 ... g = bit6, dp = 0).
  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'h3F;
      4'h1: hex7 = 8'h06;
      4'h2: hex7 = 8'h5B;
      4'h3: hex7 = 8'h4F;
      4'h4: hex7 = 8'h66;
      4'h5: hex7 = 8'h6D;
      4'h6: hex7 = 8'h7D;
      4'h7: hex7 = 8'h07;
      4'h8: hex7 = 8'h7F;
      4'h9: hex7 = 8'h6F;
      4'hA: hex7 = 8'h77;
      4'hB: hex7 = 8'h7C;
      4'hC: hex7 = 8'h39;
      4'hD: hex7 = 8'h5E;
      4'hE: hex7 = 8'h79;
      default: hex7 = 8'h71;
    endcase
  endfunction

  // A full-range modulus cannot be exceeded by a load, so the clamp only
  // exists when MAX_COUNT is below the top of the NBITS range.
  if (MAX_COUNT >= (2**NBITS) - 1) begin : g_noclamp
    assign w_load_val = data_in;
  end else begin : g_clamp
    assign w_load_val = (data_in > MAXV) ? MAXV : data_in;
  end

  // Top digit may be partial; zero-extend so its missing bits read as 0.
  assign w_pad = PADW'(r_count);
  assign w_nib = w_pad[4*r_idx +: 4];

  // Count register and terminal-count pulse: reset > load > counter_on.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else if (load) begin
      r_count <= w_load_val;
      r_tc    <= 1'b0;
    end else if (counter_on) begin
      if (count_up) begin
        if (r_count == MAXV) begin
          r_count <= WRAP ? '0 : MAXV;
          r_tc    <= 1'b1;
        end else begin
          r_count <= r_count + NBITS'(1);
          r_tc    <= 1'b0;
        end
      end else begin
        if (r_count == '0) begin
          r_count <= WRAP ? MAXV : '0;
          r_tc    <= 1'b1;
        end else begin
          r_count <= r_count - NBITS'(1);
          r_tc    <= 1'b0;
        end
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  // Scan prescaler and digit index: index advances when prescaler wraps.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PW'(SCAN_DIV - 1)) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IW'(NDIGITS - 1)) ? '0 : r_idx + IW'(1);
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Segment pattern and digit enable registered together so they never disagree.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_seg  <= 8'h3F;
      r_dsel <= NDIGITS'(1);
    end else begin
      r_seg  <= hex7(w_nib);
      r_dsel <= NDIGITS'(1) << r_idx;
    end
  end

  assign count     = r_count;
  assign tc        = r_tc;
  assign seg       = r_seg;
  assign digit_sel = r_dsel;

endmodule

// File: tb/tb_updown_counter_hex_display.sv
// Self-checking bench: four differently parameterised counters share one
// input stream and are compared each cycle against an arithmetic model.
module tb_updown_counter_hex_display;

  logic        clk_2 = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic        counter_on = 1'b0;
  logic        count_up = 1'b0;
  logic [15:0] data_in = '0;

  always #5 clk_2 = ~clk_2;

  // a: MAX 150 wrap; b: MAX 9 wrap; c: MAX 9 saturate; d: 10-bit, 3 digits, SCAN_DIV 3
  int NB[4] = '{8, 8, 8, 10};
  int MX[4] = '{150, 9, 9, 1023};
  int WR[4] = '{1, 1, 0, 1};
  int SD[4] = '{4, 4, 4, 3};
  int ND[4] = '{2, 2, 2, 3};

  logic [7:0] HEX[16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                         8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic [9:0] cnt_d;
  logic       tc_a, tc_b, tc_c, tc_d;
  logic [7:0] seg_a, seg_b, seg_c, seg_d;
  logic [1:0] ds_a, ds_b, ds_c;
  logic [2:0] ds_d;

  updown_counter_hex_display #(.NBITS(8), .MAX_COUNT(150), .WRAP(1'b1), .SCAN_DIV(4)) dut_a (
    .clk_2(clk_2), .reset(reset), .load(load), .data_in(data_in[7:0]),
    .counter_on(counter_on), .count_up(count_up),
    .count(cnt_a), .tc(tc_a), .seg(seg_a), .digit_sel(ds_a));

  updown_counter_hex_display #(.NBITS(8), .MAX_COUNT(9), .WRAP(1'b1), .SCAN_DIV(4)) dut_b (
    .clk_2(clk_2), .reset(reset), .load(load), .data_in(data_in[7:0]),
    .counter_on(counter_on), .count_up(count_up),
    .count(cnt_b), .tc(tc_b), .seg(seg_b), .digit_sel(ds_b));

  updown_counter_hex_display #(.NBITS(8), .MAX_COUNT(9), .WRAP(1'b0), .SCAN_DIV(4)) dut_c (
    .clk_2(clk_2), .reset(reset), .load(load), .data_in(data_in[7:0]),
    .counter_on(counter_on), .count_up(count_up),
    .count(cnt_c), .tc(tc_c), .seg(seg_c), .digit_sel(ds_c));

  updown_counter_hex_display #(.NBITS(10), .MAX_COUNT(1023), .WRAP(1'b1), .SCAN_DIV(3)) dut_d (
    .clk_2(clk_2), .reset(reset), .load(load), .data_in(data_in[9:0]),
    .counter_on(counter_on), .count_up(count_up),
    .count(cnt_d), .tc(tc_d), .seg(seg_d), .digit_sel(ds_d));

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: count, tc, edges since reset, expected display outputs.
  int m_cnt[4];
  int m_tc[4];
  int m_t[4];
  int e_seg[4];
  int e_dsel[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one rising edge, from the counting rules directly.
  task automatic model_step(input int k);
    int idx, nib, din, m1;
    if (reset) begin
      m_cnt[k] = 0; m_tc[k] = 0; m_t[k] = 0;
      e_seg[k] = 'h3F; e_dsel[k] = 1;
    end else begin
      idx = (m_t[k] / SD[k]) % ND[k];
      nib = (m_cnt[k] >> (4 * idx)) & 15;
      e_seg[k]  = int'(HEX[nib]);
      e_dsel[k] = 1 << idx;
      m_t[k]++;
      m1 = MX[k] + 1;
      if (load) begin
        din = int'(data_in) & ((1 << NB[k]) - 1);
        m_cnt[k] = (din > MX[k]) ? MX[k] : din;
        m_tc[k] = 0;
      end else if (counter_on) begin
        if (count_up) begin
          m_tc[k]  = (m_cnt[k] == MX[k]) ? 1 : 0;
          m_cnt[k] = WR[k] ? (m_cnt[k] + 1) % m1
                           : ((m_cnt[k] + 1 > MX[k]) ? MX[k] : m_cnt[k] + 1);
        end else begin
          m_tc[k]  = (m_cnt[k] == 0) ? 1 : 0;
          m_cnt[k] = WR[k] ? (m_cnt[k] + MX[k]) % m1
                           : ((m_cnt[k] == 0) ? 0 : m_cnt[k] - 1);
        end
      end else begin
        m_tc[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("a.count", 32'(cnt_a), m_cnt[0]); chk("a.tc", 32'(tc_a), m_tc[0]);
    chk("a.seg", 32'(seg_a), e_seg[0]);   chk("a.dsel", 32'(ds_a), e_dsel[0]);
    chk("b.count", 32'(cnt_b), m_cnt[1]); chk("b.tc", 32'(tc_b), m_tc[1]);
    chk("b.seg", 32'(seg_b), e_seg[1]);   chk("b.dsel", 32'(ds_b), e_dsel[1]);
    chk("c.count", 32'(cnt_c), m_cnt[2]); chk("c.tc", 32'(tc_c), m_tc[2]);
    chk("c.seg", 32'(seg_c), e_seg[2]);   chk("c.dsel", 32'(ds_c), e_dsel[2]);
    chk("d.count", 32'(cnt_d), m_cnt[3]); chk("d.tc", 32'(tc_d), m_tc[3]);
    chk("d.seg", 32'(seg_d), e_seg[3]);   chk("d.dsel", 32'(ds_d), e_dsel[3]);
  endtask

  task automatic step(input bit rst, input bit ld, input bit on, input bit up,
                      input logic [15:0] d);
    reset = rst; load = ld; counter_on = on; count_up = up; data_in = d;
    @(posedge clk_2);
    for (int k = 0; k < 4; k++) model_step(k);
    #1;
    check_all();
  endtask

  int pick[7] = '{0, 8, 9, 150, 200, 255, 1023};

  initial begin
    // reset then count up three times
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0);
    chk("rst.seg", 32'(seg_a), 32'h3F);
    chk("rst.dsel", 32'(ds_a), 32'h1);
    chk("rst.count", 32'(cnt_b), 32'h0);
    repeat (3) step(0, 0, 1, 1, 0);
    chk("up3.count", 32'(cnt_a), 32'd3);
    chk("up3.tc", 32'(tc_a), 32'd0);

    // modulus 9: wrap on b, saturate on c
    step(0, 1, 0, 0, 16'd8);
    step(0, 0, 1, 1, 0);
    chk("b.at9", 32'(cnt_b), 32'd9);
    step(0, 0, 1, 1, 0);
    chk("b.wrap0", 32'(cnt_b), 32'd0);
    chk("b.wraptc", 32'(tc_b), 32'd1);
    chk("c.sattc", 32'(tc_c), 32'd1);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    chk("c.sat9", 32'(cnt_c), 32'd9);
    chk("c.sattc3", 32'(tc_c), 32'd1);
    chk("b.tcpulse", 32'(tc_b), 32'd0);
    step(0, 0, 1, 0, 0);
    chk("c.down8", 32'(cnt_c), 32'd8);
    chk("c.downtc", 32'(tc_c), 32'd0);
    step(0, 1, 0, 0, 16'd0);
    step(0, 0, 1, 0, 0);
    chk("b.under9", 32'(cnt_b), 32'd9);
    chk("b.undertc", 32'(tc_b), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("b.tcdrop", 32'(tc_b), 32'd0);

    // load clamp and load-over-count priority
    step(0, 1, 0, 0, 16'd200);
    chk("a.clamp", 32'(cnt_a), 32'd150);
    chk("a.clamptc", 32'(tc_a), 32'd0);
    step(0, 1, 1, 1, 16'd5);
    chk("a.ldwins", 32'(cnt_a), 32'd5);

    // display scan of a held value
    step(0, 1, 0, 0, 16'h0A7);
    repeat (14) step(0, 0, 0, 0, 0);

    // reset mid-scan
    step(0, 1, 0, 0, 16'h05C);
    repeat (5) step(0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 16'h033);
    chk("rst2.dsel", 32'(ds_a), 32'h1);
    chk("rst2.seg", 32'(seg_d), 32'h3F);
    chk("rst2.count", 32'(cnt_d), 32'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [15:0] d;
      d = ($urandom_range(0, 2) == 0) ? 16'(pick[$urandom_range(0, 6)]) : 16'($urandom);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom), d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
